// File: rtl/restador_serie.sv
// Bit-serial subtractor: op_a - op_b - borrow_in, one bit per clock, LSB first.
// One full-subtractor cell plus one borrow flop, with a start/busy/done handshake.
module restador_serie #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             w_q, w_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [1:0]       cell_s;
    logic             last_bit_s;

    // Full-subtractor cell: returns {borrow_next, difference_bit}.
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic w);
        sub_cell = {(~a & b) | (~(a ^ b) & w), a ^ b ^ w};
    endfunction

    assign cell_s     = sub_cell(sa_q[0], sb_q[0], w_q);
    assign last_bit_s = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (last_bit_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_SHIFT: busy = 1'b1;
            S_DONE:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath next state: operand load, serial shift and result capture.
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        result_d = result_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = op_a;
                    sb_d    = op_b;
                    w_d     = borrow_in;
                    cnt_d   = {CW{1'b0}};
                    a_msb_d = op_a[WIDTH-1];
                    b_msb_d = op_b[WIDTH-1];
                end else begin
                    done_d = 1'b0;
                end
            end
            S_SHIFT: begin
                sa_d   = {1'b0, sa_q[WIDTH-1:1]};
                sb_d   = {1'b0, sb_q[WIDTH-1:1]};
                diff_d = {cell_s[0], diff_q[WIDTH-1:1]};
                w_d    = cell_s[1];
                cnt_d  = cnt_q + CW'(1);
                // The last difference bit is the result MSB, so the overflow test uses it directly.
                if (last_bit_s) begin
                    result_d = {cell_s[0], diff_q[WIDTH-1:1]};
                    bout_d   = cell_s[1];
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_s[0] != a_msb_q);
                    done_d   = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            S_DONE:  done_d = 1'b0;
            default: done_d = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q     <= {WIDTH{1'b0}};
            sb_q     <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            w_q      <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign done       = done_q;
    assign result     = result_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_restador_serie.sv
// Scoreboard bench for restador_serie: stimulus pushes expected results, a negedge
// monitor compares done timing, busy, and held result/flags every cycle.
module tb_restador_serie;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         borrow_in = 1'b0;
    logic         busy, done, borrow_out, overflow;
    logic [W-1:0] result;

    restador_serie #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .borrow_in(borrow_in), .busy(busy), .done(done), .result(result),
        .borrow_out(borrow_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         bout;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           neg_cnt = 0;
    int           last_issue = -100;
    bit           chk_en = 1'b0;
    logic [W-1:0] hold_res = '0;
    logic         hold_bout = 1'b0;
    logic         hold_ovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain (WIDTH+1)-bit arithmetic and the sign rule for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int   d;
        d      = int'(a) - int'(b) - int'(bin);
        e.res  = W'(d & ((1 << W) - 1));
        e.bout = (d < 0);
        e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        e.due  = 0;
        return e;
    endfunction

    // One stimulus cycle, driven just after the falling edge.
    task automatic drive(input logic r, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic bin);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; start = s; op_a = a; op_b = b; borrow_in = bin;
        if (r) begin
            sb.delete();
            hold_res = '0; hold_bout = 1'b0; hold_ovf = 1'b0;
            last_issue = -100;
        end else if (s && (neg_cnt >= last_issue + W + 2)) begin
            e = model(a, b, bin);
            e.due = neg_cnt + W + 1;
            sb.push_back(e);
            last_issue = neg_cnt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        drive(1'b0, 1'b1, a, b, bin);
        idle(W + 1);
    endtask

    // Monitor: done must fire exactly when due; outputs hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        logic exp_done, exp_busy;
        neg_cnt++;
        if (chk_en) begin
            exp_done = (sb.size() > 0) && (sb[0].due == neg_cnt);
            exp_busy = (neg_cnt > last_issue) && (neg_cnt <= last_issue + W + 1);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_done) begin
                e = sb.pop_front();
                hold_res = e.res; hold_bout = e.bout; hold_ovf = e.ovf;
            end
            chk("result", 32'(result), 32'(hold_res));
            chk("borrow_out", 32'(borrow_out), 32'(hold_bout));
            chk("overflow", 32'(overflow), 32'(hold_ovf));
        end
    end

    initial begin
        drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 4'd3, 4'd1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk_en = 1'b1;
        idle(2);

        op(4'b0010, 4'b1110, 1'b0);
        op(4'b0110, 4'b1111, 1'b0);
        op(4'b0000, 4'b1100, 1'b0);
        op(4'b1010, 4'b1010, 1'b1);
        op(4'b0101, 4'b0011, 1'b0);
        op(4'b0111, 4'b1000, 1'b0);
        op(4'b1000, 4'b0001, 1'b0);

        // Start pulses during SHIFT and DONE are ignored.
        drive(1'b0, 1'b1, 4'b1001, 4'b0100, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 4'b0011, 4'b0110, 1'b1);
        idle(3);

        // Reset mid-operation aborts it; reset with start does not accept.
        drive(1'b0, 1'b1, 4'b1100, 4'b0101, 1'b0);
        idle(2);
        drive(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(W + 3);
        op(4'b0100, 4'b0111, 1'b1);

        // Exhaustive operand sweep with back-to-back ops and random ignored starts.
        for (int i = 0; i < 512; i++) begin
            drive(1'b0, 1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8));
            for (int j = 0; j <= W; j++)
                drive(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(W + 3);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
